// File: rtl/decode42_key.sv
// Debounced 4-key priority encoder: synchronizes raw key lines, debounces press
// and release, and reports the accepted key index with a one-cycle valid pulse.
module decode42_key #(
    parameter int DB_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] key,
    output logic [1:0] code,
    output logic       valid,
    output logic       active,
    output logic       multi
);

    localparam int CW = $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    // state    | meaning
    // IDLE     | no key seen
    // DEBOUNCE | key pattern seen, waiting for it to stay stable
    // PRESSED  | press accepted, holding until keys go to zero
    // RELEASE  | keys zero, waiting for the release to stay stable
    typedef enum logic [1:0] {IDLE, DEBOUNCE, PRESSED, RELEASE} state_t;

    state_t        state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [3:0]    cap, cap_nx;
    logic [3:0]    sync1, ks;
    logic [1:0]    code_nx;
    logic          multi_nx, active_nx, valid_nx;

    function automatic logic [1:0] enc(input logic [3:0] v);
        if (v[3])      return 2'd3;
        else if (v[2]) return 2'd2;
        else if (v[1]) return 2'd1;
        else           return 2'd0;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1  <= '0;
            ks     <= '0;
            state  <= IDLE;
            cnt    <= '0;
            cap    <= '0;
            code   <= 2'b00;
            valid  <= 1'b0;
            active <= 1'b0;
            multi  <= 1'b0;
        end else begin
            sync1  <= key;
            ks     <= sync1;
            state  <= state_nx;
            cnt    <= cnt_nx;
            cap    <= cap_nx;
            code   <= code_nx;
            valid  <= valid_nx;
            active <= active_nx;
            multi  <= multi_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        cap_nx    = cap;
        code_nx   = code;
        multi_nx  = multi;
        active_nx = active;
        valid_nx  = 1'b0;
        case (state)
            IDLE: begin
                if (ks != 4'b0000) begin
                    state_nx = DEBOUNCE;
                    cap_nx   = ks;
                    cnt_nx   = '0;
                end
            end
            DEBOUNCE: begin
                if (ks == 4'b0000) begin
                    state_nx = IDLE;
                end else if (ks != cap) begin
                    cap_nx = ks;
                    cnt_nx = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nx  = PRESSED;
                    code_nx   = enc(cap);
                    // more than one bit set iff clearing the lowest set bit leaves something
                    multi_nx  = (cap & (cap - 4'd1)) != 4'b0000;
                    active_nx = 1'b1;
                    valid_nx  = 1'b1;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            PRESSED: begin
                if (ks == 4'b0000) begin
                    state_nx = RELEASE;
                    cnt_nx   = '0;
                end
            end
            RELEASE: begin
                if (ks != 4'b0000) begin
                    state_nx = PRESSED;
                end else if (cnt == CNT_LAST) begin
                    state_nx  = IDLE;
                    active_nx = 1'b0;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_decode42_key.sv
// Scoreboard bench for decode42_key: expected accepts are queued when a press is
// driven and matched (code, multi, exact cycle) when valid pulses.
module tb_decode42_key;

    localparam int DB = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] key;
    logic [1:0] code;
    logic       valid, active, multi;

    typedef struct {
        logic [1:0] code;
        logic       multi;
        int         at;
    } exp_t;

    exp_t sb[$];
    int   cyc   = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    decode42_key #(.DB_CYCLES(DB)) dut (
        .clk    (clk),
        .rst    (rst),
        .key    (key),
        .code   (code),
        .valid  (valid),
        .active (active),
        .multi  (multi)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Key first sampled at the next edge; valid lands DB+2 edges after that.
    task automatic press(input logic [3:0] k, input logic [1:0] c, input logic m);
        @(negedge clk);
        key = k;
        sb.push_back('{c, m, cyc + 3 + DB});
    endtask

    task automatic release_key();
        int m;
        @(negedge clk);
        key = 4'b0000;
        m = cyc;
        while (cyc < m + 2 + DB) @(negedge clk);
        check("active_before_fall", active, 1);
        @(negedge clk);
        check("active_after_fall", active, 0);
    endtask

    task automatic drain();
        int b;
        b = 0;
        while (sb.size() != 0 && b < 50) begin
            @(negedge clk);
            b++;
        end
        check("drain_pending", sb.size(), 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_code"}, code, 0);
        check({tag, "_valid"}, valid, 0);
        check({tag, "_active"}, active, 0);
        check({tag, "_multi"}, multi, 0);
    endtask

    always @(negedge clk) begin
        if (valid) begin
            if (sb.size() == 0) begin
                check("spurious_valid", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("valid_code", code, e.code);
                check("valid_multi", multi, e.multi);
                check("valid_cycle", cyc, e.at);
                check("valid_active", active, 1);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        key = 4'b0000;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;

        // single key, hold, release; code persists after release
        press(4'b0100, 2'd2, 1'b0);
        drain();
        check("held_active", active, 1);
        repeat (12) @(negedge clk);
        release_key();
        check("code_hold", code, 2);
        check("multi_hold", multi, 0);

        // two keys, priority to highest index
        press(4'b1010, 2'd3, 1'b1);
        drain();
        repeat (5) @(negedge clk);
        release_key();

        // bouncing key never stable long enough, then steady
        repeat (3) begin
            @(negedge clk);
            key = 4'b0001;
            @(negedge clk);
            @(negedge clk);
            key = 4'b0000;
            @(negedge clk);
        end
        press(4'b0001, 2'd0, 1'b0);
        drain();
        release_key();

        // added key and a one-cycle release glitch while pressed
        press(4'b0010, 2'd1, 1'b0);
        drain();
        @(negedge clk);
        key = 4'b0011;
        repeat (4) @(negedge clk);
        key = 4'b0000;
        @(negedge clk);
        key = 4'b0011;
        repeat (8) @(negedge clk);
        check("glitch_code", code, 1);
        check("glitch_active", active, 1);
        check("glitch_multi", multi, 0);
        release_key();

        // one-hot walk, encoded index decodes back to the key
        for (int i = 0; i < 4; i++) begin
            press(4'(1 << i), 2'(i), 1'b0);
            drain();
            check("led_roundtrip", 4'b0001 << code, key);
            release_key();
        end

        // reset in the middle of debounce
        @(negedge clk);
        key = 4'b0100;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_all_zero("rst_debounce");
        sb.push_back('{2'd2, 1'b0, cyc + 3 + DB});
        drain();

        // reset while pressed
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_all_zero("rst_pressed");
        sb.push_back('{2'd2, 1'b0, cyc + 3 + DB});
        drain();
        release_key();

        repeat (20) @(negedge clk);
        check("sb_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
